master_start: RTL and testbench
===============================

MASTER_START -- requirements
Module: master_start

Interface
REQ-001 CLK  in  1  -- 48 MHz system clock; single clock domain, all logic on rising edge.
REQ-002 RESET  in  1  -- synchronous, active-high reset.
REQ-003 SYS_TIME  in  64  -- preset value for TIME, loaded on an armed second mark.
REQ-004 SYS_TIME_UPDATE  in  1  -- level; arms a TIME preset at the next T1hz rising edge.
REQ-005 T1hz  in  1  -- second mark; asynchronous; block synchronizes it and detects its rising edge.
REQ-006 TIME  out  64  -- system time counter in CLK cycles.
REQ-007 SYS_TIME_UPDATE_OK  out  1  -- one-cycle pulse when the preset is applied.
REQ-008 REQ_COMMAND  out  1  -- high while the block is ready to accept a new command.
REQ-009 WR_DATA  in  1  -- command strobe; MEM_* valid in that cycle.
REQ-010 MEM_DDS_freq 48, MEM_DDS_delta_freq 48, MEM_DDS_delta_rate 32, MEM_TIME_START 64, MEM_N_impuls 16, MEM_TYPE_impulse 2, MEM_Interval_Ti 32, MEM_Interval_Tp 32, MEM_Tblank1 32, MEM_Tblank2 32  in  -- command fields; all durations are in CLK cycles.
REQ-011 DDS_freq 48, DDS_delta_freq 48, DDS_delta_rate 32  out  -- DDS programming words.
REQ-012 REQ  out  1, ACK  in  1  -- four-phase handshake toward the DDS.
REQ-013 DDS_start  out  1  -- DDS run enable.
REQ-014 En_Iz / En_Pr  out  1  -- transmit / receive windows.

Function
REQ-015 TIME shall increment by 1 every cycle and wrap modulo 2^64.
REQ-016 A SYS_TIME_UPDATE high level shall set an arm flag. On a T1hz rising edge while armed, TIME shall load SYS_TIME, SYS_TIME_UPDATE_OK shall pulse for 1 cycle, and the arm flag shall clear. A T1hz edge while unarmed shall be ignored.
REQ-017 FSM states: IDLE, LOAD, HANDSHAKE, WAIT_START, BLANK1, TI, BLANK2, TP.
REQ-018 IDLE: REQ_COMMAND=1. When WR_DATA=1, all MEM_* fields shall be latched, REQ_COMMAND shall fall on the next cycle, and the FSM shall go to LOAD.
REQ-019 LOAD: the DDS_* outputs shall take the latched words, REQ shall go to 1, and the FSM shall go to HANDSHAKE.
REQ-020 HANDSHAKE: REQ shall stay 1 with DDS_* stable until ACK=1. REQ shall then drop. The FSM shall go to WAIT_START once ACK=0.
REQ-021 WAIT_START: the burst shall start on the first cycle with TIME >= TIME_START (unsigned compare), so a TIME preset jump shall never strand a command.
REQ-022 Each impulse shall run BLANK1 (Tblank1 cycles), then TI (Ti cycles, En_Iz=1), then BLANK2 (Tblank2 cycles), then TP (Tp cycles, En_Pr=1). One impulse therefore spans Tblank1+Ti+Tblank2+Tp cycles with no gap between phases or between impulses.
REQ-023 A phase with a duration of 0 shall be skipped (0 cycles).
REQ-024 En_Iz and En_Pr shall never be high together.
REQ-025 TYPE=0 (non-coherent): DDS_start shall equal En_Iz, restarting the chirp on every impulse. TYPE>=1 (coherent): DDS_start shall rise with the first TI and stay high until the last TP ends.
REQ-026 After N impulses the FSM shall return to IDLE and set REQ_COMMAND=1. N=0 shall return to IDLE directly from WAIT_START.
REQ-027 WR_DATA outside IDLE shall be ignored. Phase counters shall be independent of TIME, so a preset mid-burst shall not alter burst timing.

Reset
REQ-028 During RESET all outputs shall be 0 (TIME=0, REQ_COMMAND=0), the FSM shall be in IDLE, and the arm flag shall be clear. REQ_COMMAND shall rise on the first cycle after reset release.
REQ-029 RESET asserted mid-burst or mid-handshake shall abort immediately and discard the latched command.

Structure
REQ-030 A package master_start_pkg shall hold the FSM state enum, the TYPE encodings (NONCOH=0, COH=1), and the field-width constants.
REQ-031 One sub-module, sys_time_counter, shall hold TIME, the T1hz synchronizer and edge detector, the arm flag, and SYS_TIME_UPDATE_OK.

Verification
REQ-032 Preset: SYS_TIME_UPDATE pulse, then T1hz edge with SYS_TIME=1000 -> TIME=1000 on the next cycle, one SYS_TIME_UPDATE_OK pulse. A second T1hz edge without arming -> no load.
REQ-033 Command FREQ=43980465111040, STEP=2932031, RATE=1 -> REQ=1 with these words held until ACK, then REQ=0.
REQ-034 START=480000, N=10, Ti=Tp=4800, Tb1=Tb2=480, TYPE=0 -> En_Iz high at TIME 480480..485279. Burst ends 105600 cycles after start. Ten En_Iz and ten En_Pr windows of 4800 cycles. DDS_start == En_Iz.
REQ-035 Same command with TYPE=1 -> DDS_start high continuously from the first En_Iz to the end of the last En_Pr.
REQ-036 START already below TIME at load -> burst starts immediately after the handshake. N=0 -> REQ_COMMAND returns with no En_* activity.
REQ-037 RESET mid-TI -> En_Iz=0, DDS_start=0 and REQ_COMMAND=0 while RESET is held, then REQ_COMMAND=1 one cycle after release.

Source files
------------

// File: rtl/master_start_pkg.sv
// Shared types for the burst sequencer: FSM states, impulse type codes, field widths, command record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package master_start_pkg;

  localparam int TIME_W = 64;
  localparam int FREQ_W = 48;
  localparam int RATE_W = 32;
  localparam int N_W    = 16;
  localparam int TYPE_W = 2;
  localparam int DUR_W  = 32;

  localparam logic [TYPE_W-1:0] TYPE_NONCOH = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_COH    = 2'd1;

  // Burst phase states sit at 4..7 so their low two bits are the phase index.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_HANDSHAKE  = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_BLANK1     = 3'd4,
    ST_TI         = 3'd5,
    ST_BLANK2     = 3'd6,
    ST_TP         = 3'd7
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] dds_freq;
    logic [FREQ_W-1:0] delta_freq;
    logic [RATE_W-1:0] delta_rate;
    logic [TIME_W-1:0] time_start;
    logic [N_W-1:0]    n_impuls;
    logic [TYPE_W-1:0] type_impulse;
    logic [DUR_W-1:0]  ti;
    logic [DUR_W-1:0]  tp;
    logic [DUR_W-1:0]  tblank1;
    logic [DUR_W-1:0]  tblank2;
  } cmd_t;

  // Lowest phase index >= from whose duration is non-zero; 4 means none left.
  function automatic logic [2:0] first_phase(input logic [3:0] nz, input logic [2:0] from);
    logic [2:0] res;
    res = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && nz[i]) res = 3'(i);
    end
    return res;
  endfunction

  function automatic logic [DUR_W-1:0] phase_dur(input cmd_t c, input logic [1:0] ph);
    logic [DUR_W-1:0] d;
    case (ph)
      2'd0:    d = c.tblank1;
      2'd1:    d = c.ti;
      2'd2:    d = c.tblank2;
      default: d = c.tp;
    endcase
    return d;
  endfunction

  function automatic state_t phase_state(input logic [1:0] ph);
    state_t s;
    case (ph)
      2'd0:    s = ST_BLANK1;
      2'd1:    s = ST_TI;
      2'd2:    s = ST_BLANK2;
      default: s = ST_TP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/master_start_sys_time.sv
// System time counter with armed preset on the synchronized rising edge of the 1 Hz mark.
// Latency: TIME loads 3 cycles after T1hz rises (2-flop sync + edge detect); OK pulses with the load.
// Backpressure: none; SYS_TIME_UPDATE is a level that arms the next edge.
module sys_time_counter
  import master_start_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [TIME_W-1:0] i_sys_time,
  input  logic              i_sys_time_update,
  input  logic              i_t1hz,
  output logic [TIME_W-1:0] o_time,
  output logic [TIME_W-1:0] o_time_nxt,
  output logic              o_update_ok
);

  logic [1:0]        r_sync;
  logic              r_t1_prev;
  logic              r_arm;
  logic              r_ok;
  logic [TIME_W-1:0] r_time;
  logic              w_edge;
  logic              w_load;

  assign w_edge      = r_sync[1] & ~r_t1_prev;
  assign w_load      = w_edge & r_arm;
  // Value TIME holds next cycle; the sequencer compares against this so the
  // first burst cycle is exactly the one where TIME reaches TIME_START.
  assign o_time_nxt  = w_load ? i_sys_time : r_time + 64'd1;
  assign o_time      = r_time;
  assign o_update_ok = r_ok;

  // Synchronize T1hz, run the time counter, and manage the preset arm flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync    <= 2'b00;
      r_t1_prev <= 1'b0;
      r_arm     <= 1'b0;
      r_ok      <= 1'b0;
      r_time    <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_t1hz};
      r_t1_prev <= r_sync[1];
      r_time    <= o_time_nxt;
      r_ok      <= w_load;
      r_arm     <= w_load ? 1'b0 : (r_arm | i_sys_time_update);
    end
  end

endmodule

// File: rtl/master_start.sv
// Command sequencer: latches a burst command, hands DDS words over a 4-phase REQ/ACK, then plays N impulses at TIME_START.
// Latency: REQ rises 2 cycles after WR_DATA; first burst cycle is the one where TIME >= TIME_START.
// Backpressure: REQ_COMMAND low while busy, WR_DATA ignored then; HANDSHAKE holds until ACK rises and falls.
module master_start
  import master_start_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [TIME_W-1:0] i_sys_time,
  input  logic              i_sys_time_update,
  input  logic              i_t1hz,
  output logic [TIME_W-1:0] o_time,
  output logic              o_sys_time_update_ok,
  output logic              o_req_command,
  input  logic              i_wr_data,
  input  logic [FREQ_W-1:0] i_mem_dds_freq,
  input  logic [FREQ_W-1:0] i_mem_dds_delta_freq,
  input  logic [RATE_W-1:0] i_mem_dds_delta_rate,
  input  logic [TIME_W-1:0] i_mem_time_start,
  input  logic [N_W-1:0]    i_mem_n_impuls,
  input  logic [TYPE_W-1:0] i_mem_type_impulse,
  input  logic [DUR_W-1:0]  i_mem_interval_ti,
  input  logic [DUR_W-1:0]  i_mem_interval_tp,
  input  logic [DUR_W-1:0]  i_mem_tblank1,
  input  logic [DUR_W-1:0]  i_mem_tblank2,
  output logic [FREQ_W-1:0] o_dds_freq,
  output logic [FREQ_W-1:0] o_dds_delta_freq,
  output logic [RATE_W-1:0] o_dds_delta_rate,
  output logic              o_req,
  input  logic              i_ack,
  output logic              o_dds_start,
  output logic              o_en_iz,
  output logic              o_en_pr
);

  logic [TIME_W-1:0] w_time_nxt;
  cmd_t              w_mem_cmd;
  logic [3:0]        w_nz;
  logic [2:0]        w_ph_first;
  logic [2:0]        w_ph_rest;
  state_t            w_nxt;
  logic [DUR_W-1:0]  w_nxt_cnt;
  logic [N_W-1:0]    w_nxt_left;
  logic              w_go;
  logic [1:0]        w_go_ph;
  logic              w_nxt_burst;

  state_t            r_state;
  cmd_t              r_cmd;
  logic [N_W-1:0]    r_left;
  logic [DUR_W-1:0]  r_cnt;
  logic              r_req_command;
  logic              r_req;
  logic [FREQ_W-1:0] r_dds_freq;
  logic [FREQ_W-1:0] r_dds_delta_freq;
  logic [RATE_W-1:0] r_dds_delta_rate;
  logic              r_dds_start;
  logic              r_en_iz;
  logic              r_en_pr;

  sys_time_counter u_sys_time (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_sys_time        (i_sys_time),
    .i_sys_time_update (i_sys_time_update),
    .i_t1hz            (i_t1hz),
    .o_time            (o_time),
    .o_time_nxt        (w_time_nxt),
    .o_update_ok       (o_sys_time_update_ok)
  );

  assign w_mem_cmd.dds_freq     = i_mem_dds_freq;
  assign w_mem_cmd.delta_freq   = i_mem_dds_delta_freq;
  assign w_mem_cmd.delta_rate   = i_mem_dds_delta_rate;
  assign w_mem_cmd.time_start   = i_mem_time_start;
  assign w_mem_cmd.n_impuls     = i_mem_n_impuls;
  assign w_mem_cmd.type_impulse = i_mem_type_impulse;
  assign w_mem_cmd.ti           = i_mem_interval_ti;
  assign w_mem_cmd.tp           = i_mem_interval_tp;
  assign w_mem_cmd.tblank1      = i_mem_tblank1;
  assign w_mem_cmd.tblank2      = i_mem_tblank2;

  // Zero-length phases are skipped by searching for the next non-zero one.
  assign w_nz       = {r_cmd.tp != '0, r_cmd.tblank2 != '0, r_cmd.ti != '0, r_cmd.tblank1 != '0};
  assign w_ph_first = first_phase(w_nz, 3'd0);
  assign w_ph_rest  = first_phase(w_nz, {1'b0, r_state[1:0]} + 3'd1);

  // Next-state, phase counter and remaining-impulse computation.
  always_comb begin
    w_nxt      = r_state;
    w_nxt_cnt  = r_cnt;
    w_nxt_left = r_left;
    w_go       = 1'b0;
    w_go_ph    = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_data) w_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_nxt = ST_HANDSHAKE;
      end
      ST_HANDSHAKE: begin
        if (!r_req && !i_ack) w_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (w_time_nxt >= r_cmd.time_start) begin
          if ((r_cmd.n_impuls == '0) || w_ph_first[2]) begin
            w_nxt = ST_IDLE;
          end else begin
            w_go       = 1'b1;
            w_go_ph    = w_ph_first[1:0];
            w_nxt_left = r_cmd.n_impuls - 16'd1;
          end
        end
      end
      default: begin
        if (r_cnt != '0) begin
          w_nxt_cnt = r_cnt - 32'd1;
        end else if (!w_ph_rest[2]) begin
          w_go    = 1'b1;
          w_go_ph = w_ph_rest[1:0];
        end else if (r_left != '0) begin
          w_go       = 1'b1;
          w_go_ph    = w_ph_first[1:0];
          w_nxt_left = r_left - 16'd1;
        end else begin
          w_nxt = ST_IDLE;
        end
      end
    endcase
    if (w_go) begin
      w_nxt     = phase_state(w_go_ph);
      w_nxt_cnt = phase_dur(r_cmd, w_go_ph) - 32'd1;
    end
  end

  assign w_nxt_burst = (w_nxt == ST_BLANK1) || (w_nxt == ST_TI) ||
                       (w_nxt == ST_BLANK2) || (w_nxt == ST_TP);

  // Sequencer state and registered outputs, all derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_cmd            <= '0;
      r_left           <= '0;
      r_cnt            <= '0;
      r_req_command    <= 1'b0;
      r_req            <= 1'b0;
      r_dds_freq       <= '0;
      r_dds_delta_freq <= '0;
      r_dds_delta_rate <= '0;
      r_dds_start      <= 1'b0;
      r_en_iz          <= 1'b0;
      r_en_pr          <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_cnt         <= w_nxt_cnt;
      r_left        <= w_nxt_left;
      r_req_command <= (w_nxt == ST_IDLE);
      r_en_iz       <= (w_nxt == ST_TI);
      r_en_pr       <= (w_nxt == ST_TP);
      if ((r_state == ST_IDLE) && i_wr_data) r_cmd <= w_mem_cmd;
      if (r_state == ST_LOAD) begin
        r_dds_freq       <= r_cmd.dds_freq;
        r_dds_delta_freq <= r_cmd.delta_freq;
        r_dds_delta_rate <= r_cmd.delta_rate;
        r_req            <= 1'b1;
      end else if ((r_state == ST_HANDSHAKE) && i_ack) begin
        r_req <= 1'b0;
      end
      // Non-coherent restarts the chirp each TI; coherent holds from first TI to burst end.
      if (r_cmd.type_impulse == TYPE_NONCOH) r_dds_start <= (w_nxt == ST_TI);
      else r_dds_start <= w_nxt_burst && (r_dds_start || (w_nxt == ST_TI));
    end
  end

  assign o_req_command    = r_req_command;
  assign o_req            = r_req;
  assign o_dds_freq       = r_dds_freq;
  assign o_dds_delta_freq = r_dds_delta_freq;
  assign o_dds_delta_rate = r_dds_delta_rate;
  assign o_dds_start      = r_dds_start;
  assign o_en_iz          = r_en_iz;
  assign o_en_pr          = r_en_pr;

endmodule

// File: tb/tb_master_start.sv
// Directed self-checking bench for master_start: reset, TIME preset, DDS handshake, bursts, reset abort.
// Latency: n/a (bench).
// Backpressure: ACK driven by the bench with a few cycles of hold.
module tb_master_start;

  logic        clk;
  logic        i_reset;
  logic [63:0] i_sys_time;
  logic        i_sys_time_update;
  logic        i_t1hz;
  logic [63:0] o_time;
  logic        o_sys_time_update_ok;
  logic        o_req_command;
  logic        i_wr_data;
  logic [47:0] i_mem_dds_freq;
  logic [47:0] i_mem_dds_delta_freq;
  logic [31:0] i_mem_dds_delta_rate;
  logic [63:0] i_mem_time_start;
  logic [15:0] i_mem_n_impuls;
  logic [1:0]  i_mem_type_impulse;
  logic [31:0] i_mem_interval_ti;
  logic [31:0] i_mem_interval_tp;
  logic [31:0] i_mem_tblank1;
  logic [31:0] i_mem_tblank2;
  logic [47:0] o_dds_freq;
  logic [47:0] o_dds_delta_freq;
  logic [31:0] o_dds_delta_rate;
  logic        o_req;
  logic        i_ack;
  logic        o_dds_start;
  logic        o_en_iz;
  logic        o_en_pr;

  int n_cmp;
  int n_err;

  master_start dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_sys_time           (i_sys_time),
    .i_sys_time_update    (i_sys_time_update),
    .i_t1hz               (i_t1hz),
    .o_time               (o_time),
    .o_sys_time_update_ok (o_sys_time_update_ok),
    .o_req_command        (o_req_command),
    .i_wr_data            (i_wr_data),
    .i_mem_dds_freq       (i_mem_dds_freq),
    .i_mem_dds_delta_freq (i_mem_dds_delta_freq),
    .i_mem_dds_delta_rate (i_mem_dds_delta_rate),
    .i_mem_time_start     (i_mem_time_start),
    .i_mem_n_impuls       (i_mem_n_impuls),
    .i_mem_type_impulse   (i_mem_type_impulse),
    .i_mem_interval_ti    (i_mem_interval_ti),
    .i_mem_interval_tp    (i_mem_interval_tp),
    .i_mem_tblank1        (i_mem_tblank1),
    .i_mem_tblank2        (i_mem_tblank2),
    .o_dds_freq           (o_dds_freq),
    .o_dds_delta_freq     (o_dds_delta_freq),
    .o_dds_delta_rate     (o_dds_delta_rate),
    .o_req                (o_req),
    .i_ack                (i_ack),
    .o_dds_start          (o_dds_start),
    .o_en_iz              (o_en_iz),
    .o_en_pr              (o_en_pr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Burst monitor results
  int          m_iz_n, m_pr_n, m_iz_min, m_iz_max, m_pr_min, m_pr_max;
  int          m_overlap, m_dds_neq, m_dds_rise, m_dds_hi;
  logic [63:0] m_iz_first, m_iz_first_last, m_end;
  logic        m_done;

  task automatic monitor(input int budget);
    int   iz_len, pr_len;
    logic p_iz, p_pr, p_dds;
    m_iz_n = 0; m_pr_n = 0; m_overlap = 0; m_dds_neq = 0; m_dds_rise = 0; m_dds_hi = 0;
    m_iz_min = 32'h7fffffff; m_iz_max = 0; m_pr_min = 32'h7fffffff; m_pr_max = 0;
    m_iz_first = 0; m_iz_first_last = 0; m_end = 0; m_done = 1'b0;
    iz_len = 0; pr_len = 0; p_iz = 1'b0; p_pr = 1'b0; p_dds = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_en_iz && o_en_pr) m_overlap++;
      if (o_dds_start != o_en_iz) m_dds_neq++;
      if (o_dds_start) m_dds_hi++;
      if (o_dds_start && !p_dds) m_dds_rise++;
      if (o_en_iz && !p_iz) begin
        m_iz_n++;
        if (m_iz_n == 1) m_iz_first = o_time;
        iz_len = 0;
      end
      if (o_en_iz) iz_len++;
      if (!o_en_iz && p_iz) begin
        if (m_iz_n == 1) m_iz_first_last = o_time - 64'd1;
        if (iz_len < m_iz_min) m_iz_min = iz_len;
        if (iz_len > m_iz_max) m_iz_max = iz_len;
      end
      if (o_en_pr && !p_pr) begin m_pr_n++; pr_len = 0; end
      if (o_en_pr) pr_len++;
      if (!o_en_pr && p_pr) begin
        if (pr_len < m_pr_min) m_pr_min = pr_len;
        if (pr_len > m_pr_max) m_pr_max = pr_len;
      end
      p_iz = o_en_iz; p_pr = o_en_pr; p_dds = o_dds_start;
      if (o_req_command) begin
        m_done = 1'b1;
        m_end  = o_time;
        break;
      end
    end
  endtask

  task automatic do_preset(input logic [63:0] v, input logic arm,
                           output int oks, output logic [63:0] t_ok, output int k_ok);
    i_sys_time = v;
    if (arm) begin
      i_sys_time_update = 1'b1;
      @(negedge clk);
      i_sys_time_update = 1'b0;
    end
    i_t1hz = 1'b1;
    oks = 0; t_ok = 0; k_ok = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_sys_time_update_ok) begin oks++; t_ok = o_time; k_ok = k; end
    end
    i_t1hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [47:0] f, input logic [47:0] df, input logic [31:0] rt,
                          input logic [63:0] st, input logic [15:0] n, input logic [1:0] ty,
                          input logic [31:0] ti, input logic [31:0] tp,
                          input logic [31:0] b1, input logic [31:0] b2);
    int c;
    c = 0;
    while (!o_req_command && c < 50) begin @(negedge clk); c++; end
    chk("cmd_ready", o_req_command, 1);
    i_mem_dds_freq = f; i_mem_dds_delta_freq = df; i_mem_dds_delta_rate = rt;
    i_mem_time_start = st; i_mem_n_impuls = n; i_mem_type_impulse = ty;
    i_mem_interval_ti = ti; i_mem_interval_tp = tp; i_mem_tblank1 = b1; i_mem_tblank2 = b2;
    i_wr_data = 1'b1;
    @(negedge clk);
    i_wr_data = 1'b0;
    chk("cmd_taken_req_command_low", o_req_command, 0);
  endtask

  task automatic hs(output logic [63:0] t_rel);
    int c;
    c = 0;
    while (!o_req && c < 20) begin @(negedge clk); c++; end
    chk("hs_req_up", o_req, 1);
    repeat (3) @(negedge clk);
    i_ack = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (o_req && c < 20);
    chk("hs_req_down", o_req, 0);
    i_ack = 1'b0;
    t_rel = o_time;
  endtask

  initial begin
    int          oks, k_ok, iz_cnt;
    logic [63:0] t_ok, t0, t_rel;
    n_cmp = 0; n_err = 0;
    i_reset = 1'b1; i_sys_time = '0; i_sys_time_update = 1'b0; i_t1hz = 1'b0;
    i_wr_data = 1'b0; i_ack = 1'b0;
    i_mem_dds_freq = '0; i_mem_dds_delta_freq = '0; i_mem_dds_delta_rate = '0;
    i_mem_time_start = '0; i_mem_n_impuls = '0; i_mem_type_impulse = '0;
    i_mem_interval_ti = '0; i_mem_interval_tp = '0; i_mem_tblank1 = '0; i_mem_tblank2 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_time", o_time, 0);
    chk("rst_req_command", o_req_command, 0);
    chk("rst_req", o_req, 0);
    chk("rst_en_iz", o_en_iz, 0);
    chk("rst_dds_start", o_dds_start, 0);
    chk("rst_update_ok", o_sys_time_update_ok, 0);
    i_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_command", o_req_command, 1);
    chk("post_rst_time", o_time, 1);

    // Armed preset to 1000, then an unarmed edge
    do_preset(64'd1000, 1'b1, oks, t_ok, k_ok);
    chk("preset_ok_pulses", oks, 1);
    chk("preset_time_value", t_ok, 1000);
    chk("preset_latency", k_ok, 2);
    chk("preset_time_runs_on", o_time, t_ok + 64'(7 - k_ok) + 64'd4);
    t0 = o_time;
    do_preset(64'd5555, 1'b0, oks, t_ok, k_ok);
    chk("unarmed_ok_pulses", oks, 0);
    chk("unarmed_time_no_load", o_time, t0 + 64'd12);

    // Preset close to the command start time
    do_preset(64'd470000, 1'b1, oks, t_ok, k_ok);
    chk("preset2_time_value", t_ok, 470000);

    // Full-size non-coherent command (2 impulses), DDS words and handshake
    send_cmd(48'd43980465111040, 48'd2932031, 32'd1, 64'd480000, 16'd2, 2'd0,
             32'd4800, 32'd4800, 32'd480, 32'd480);
    @(negedge clk);
    chk("load_req", o_req, 1);
    chk("load_dds_freq", o_dds_freq, 48'd43980465111040);
    chk("load_dds_delta_freq", o_dds_delta_freq, 48'd2932031);
    chk("load_dds_delta_rate", o_dds_delta_rate, 1);
    // WR_DATA while busy carries a different command and must be ignored
    i_mem_dds_freq = 48'd5; i_mem_n_impuls = 16'd7; i_mem_time_start = 64'd0;
    i_wr_data = 1'b1;
    @(negedge clk);
    i_wr_data = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_req_without_ack", o_req, 1);
    chk("hold_dds_freq", o_dds_freq, 48'd43980465111040);
    hs(t_rel);
    chk("after_hs_dds_freq", o_dds_freq, 48'd43980465111040);
    monitor(40000);
    chk("b0_done", m_done, 1);
    chk("b0_iz_first_rise", m_iz_first, 480480);
    chk("b0_iz_first_last", m_iz_first_last, 485279);
    chk("b0_end_time", m_end, 480000 + 21120);
    chk("b0_iz_windows", m_iz_n, 2);
    chk("b0_pr_windows", m_pr_n, 2);
    chk("b0_iz_min_len", m_iz_min, 4800);
    chk("b0_iz_max_len", m_iz_max, 4800);
    chk("b0_pr_min_len", m_pr_min, 4800);
    chk("b0_pr_max_len", m_pr_max, 4800);
    chk("b0_overlap", m_overlap, 0);
    chk("b0_dds_eq_iz", m_dds_neq, 0);

    // Coherent, start already in the past, scaled durations
    send_cmd(48'd1, 48'd2, 32'd3, 64'd0, 16'd3, 2'd1, 32'd48, 32'd48, 32'd5, 32'd5);
    hs(t_rel);
    monitor(2000);
    chk("b1_done", m_done, 1);
    chk("b1_iz_first_rise", m_iz_first, t_rel + 64'd7);
    chk("b1_end_time", m_end, t_rel + 64'd320);
    chk("b1_iz_windows", m_iz_n, 3);
    chk("b1_pr_windows", m_pr_n, 3);
    chk("b1_iz_len", m_iz_max, 48);
    chk("b1_pr_len", m_pr_min, 48);
    chk("b1_overlap", m_overlap, 0);
    chk("b1_dds_rises", m_dds_rise, 1);
    chk("b1_dds_high_cycles", m_dds_hi, 313);

    // Zero-length blanks are skipped: impulse = TI then TP back to back
    send_cmd(48'd1, 48'd2, 32'd3, 64'd0, 16'd2, 2'd0, 32'd6, 32'd4, 32'd0, 32'd0);
    hs(t_rel);
    monitor(200);
    chk("b2_iz_first_rise", m_iz_first, t_rel + 64'd2);
    chk("b2_end_time", m_end, t_rel + 64'd22);
    chk("b2_iz_windows", m_iz_n, 2);
    chk("b2_pr_len", m_pr_max, 4);

    // N = 0 returns to IDLE with no window activity
    send_cmd(48'd1, 48'd2, 32'd3, 64'd0, 16'd0, 2'd1, 32'd10, 32'd10, 32'd2, 32'd2);
    hs(t_rel);
    monitor(100);
    chk("n0_end_time", m_end, t_rel + 64'd2);
    chk("n0_iz_windows", m_iz_n, 0);
    chk("n0_pr_windows", m_pr_n, 0);

    // Reset in the middle of TI
    send_cmd(48'd1, 48'd2, 32'd3, 64'd0, 16'd1, 2'd1, 32'd1000, 32'd10, 32'd5, 32'd5);
    hs(t_rel);
    begin
      int c;
      c = 0;
      while (!o_en_iz && c < 50) begin @(negedge clk); c++; end
    end
    chk("rst_mid_iz_seen", o_en_iz, 1);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_en_iz", o_en_iz, 0);
    chk("rst_mid_dds_start", o_dds_start, 0);
    chk("rst_mid_req_command", o_req_command, 0);
    chk("rst_mid_time", o_time, 0);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_release_req_command", o_req_command, 1);
    iz_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_en_iz || o_en_pr || o_dds_start || o_req) iz_cnt++;
    end
    chk("rst_mid_cmd_discarded", iz_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
